// File: rtl/dcache_wt.sv
// Direct-mapped, write-through, no-write-allocate data cache with one word per line.
// Loads hit in zero cycles; misses and all stores stall while the backing memory is serviced.
module dcache_wt #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int INDEX_BITS = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  input  logic                  reqValid_i,
  input  logic                  reqWrite_i,
  input  logic [ADDR_WIDTH-1:0] addr_i,
  input  logic [DATA_WIDTH-1:0] writeData_i,
  input  logic                  flush_i,
  output logic [DATA_WIDTH-1:0] readData_o,
  output logic                  stall_o,
  output logic                  memReq_o,
  output logic                  memWe_o,
  output logic [ADDR_WIDTH-1:0] memAddr_o,
  output logic [DATA_WIDTH-1:0] memWData_o,
  input  logic                  memAck_i,
  input  logic [DATA_WIDTH-1:0] memRData_i,
  output logic [31:0]           hitCount_o,
  output logic [31:0]           missCount_o
);

  localparam int LINES = 1 << INDEX_BITS;
  localparam int TAG_W = ADDR_WIDTH - INDEX_BITS - 2;

  typedef enum logic [1:0] {IDLE, FILL, WRITE} state_t;

  state_t                  state, state_nx;
  logic [LINES-1:0]        valid;
  logic [TAG_W-1:0]        tag_mem  [LINES];
  logic [DATA_WIDTH-1:0]   data_mem [LINES];
  logic                    done;

  logic [INDEX_BITS-1:0]   req_idx, fill_idx;
  logic [TAG_W-1:0]        req_tag, fill_tag;
  logic                    hit;
  logic                    load_hit, load_miss, store_go, flush_go, done_clr;
  logic                    unused_addr_lsb;

  assign req_idx  = addr_i[INDEX_BITS+1:2];
  assign req_tag  = addr_i[ADDR_WIDTH-1:INDEX_BITS+2];
  // Fill target comes from the latched request address, not the CPU bus.
  assign fill_idx = memAddr_o[INDEX_BITS+1:2];
  assign fill_tag = memAddr_o[ADDR_WIDTH-1:INDEX_BITS+2];
  assign hit      = valid[req_idx] && (tag_mem[req_idx] == req_tag);
  assign unused_addr_lsb = ^addr_i[1:0];

  always_comb begin
    state_nx   = state;
    stall_o    = 1'b0;
    readData_o = '0;
    load_hit   = 1'b0;
    load_miss  = 1'b0;
    store_go   = 1'b0;
    flush_go   = 1'b0;
    done_clr   = 1'b0;
    case (state)
      IDLE: begin
        if (flush_i) begin
          stall_o  = 1'b1;
          flush_go = 1'b1;
        end else begin
          // The done flag only lives for the single IDLE cycle after a write ack.
          done_clr = 1'b1;
          if (reqValid_i) begin
            if (reqWrite_i) begin
              if (!done) begin
                stall_o  = 1'b1;
                store_go = 1'b1;
                state_nx = WRITE;
              end
            end else if (hit) begin
              readData_o = data_mem[req_idx];
              load_hit   = 1'b1;
            end else begin
              stall_o   = 1'b1;
              load_miss = 1'b1;
              state_nx  = FILL;
            end
          end
        end
      end
      FILL: begin
        stall_o = 1'b1;
        if (memAck_i) state_nx = IDLE;
      end
      WRITE: begin
        stall_o = 1'b1;
        if (memAck_i) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state       <= IDLE;
      valid       <= '0;
      done        <= 1'b0;
      memReq_o    <= 1'b0;
      memWe_o     <= 1'b0;
      memAddr_o   <= '0;
      memWData_o  <= '0;
      hitCount_o  <= '0;
      missCount_o <= '0;
    end else begin
      state <= state_nx;

      if (flush_go)
        valid <= '0;
      else if (state == FILL && memAck_i)
        valid[fill_idx] <= 1'b1;

      if (state == WRITE && memAck_i)
        done <= 1'b1;
      else if (done_clr)
        done <= 1'b0;

      if (load_miss || store_go) begin
        memReq_o  <= 1'b1;
        memWe_o   <= store_go;
        memAddr_o <= {addr_i[ADDR_WIDTH-1:2], 2'b00};
      end else if ((state == FILL || state == WRITE) && memAck_i) begin
        memReq_o <= 1'b0;
        memWe_o  <= 1'b0;
      end

      if (store_go)
        memWData_o <= writeData_i;

      if (load_hit && hitCount_o != 32'hFFFF_FFFF)
        hitCount_o <= hitCount_o + 32'd1;
      if (load_miss && missCount_o != 32'hFFFF_FFFF)
        missCount_o <= missCount_o + 32'd1;
    end
  end

  // Tag/data arrays carry no reset; the valid bits alone qualify them.
  always_ff @(posedge clk_i) begin
    if (state == FILL && memAck_i) begin
      data_mem[fill_idx] <= memRData_i;
      tag_mem[fill_idx]  <= fill_tag;
    end else if (store_go && hit) begin
      data_mem[req_idx] <= writeData_i;
    end
  end

endmodule

// File: tb/tb_dcache_wt.sv
// Directed testbench for dcache_wt: CPU requests are driven per scenario task and the
// backing memory is emulated inline with a configurable acknowledge latency.
module tb_dcache_wt;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        reqValid, reqWrite, flush;
  logic [31:0] addr, wdata;
  logic [31:0] readData;
  logic        stall;
  logic        memReq, memWe;
  logic [31:0] memAddr, memWData;
  logic        memAck;
  logic [31:0] memRData;
  logic [31:0] hitCount, missCount;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  dcache_wt #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .INDEX_BITS(4)) dut (
    .clk_i(clk), .rst_n_i(rst_n),
    .reqValid_i(reqValid), .reqWrite_i(reqWrite), .addr_i(addr),
    .writeData_i(wdata), .flush_i(flush),
    .readData_o(readData), .stall_o(stall),
    .memReq_o(memReq), .memWe_o(memWe), .memAddr_o(memAddr), .memWData_o(memWData),
    .memAck_i(memAck), .memRData_i(memRData),
    .hitCount_o(hitCount), .missCount_o(missCount)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reqValid = 0; reqWrite = 0; flush = 0; addr = 0; wdata = 0;
    memAck = 0; memRData = 0;
    rst_n = 0;
    #12;
    @(negedge clk);
    rst_n = 1;
    step();
  endtask

  // Holds one CPU request until stall drops; memory acks on the (lat+1)th request cycle.
  task automatic cpu_access(input logic wr, input logic [31:0] a, input logic [31:0] wd,
                            input logic [31:0] fill, input int lat,
                            output int stalls, output logic [31:0] rdata,
                            output logic [31:0] maddr, output logic we_seen,
                            output logic bad_hs, output logic timeout);
    int reqc;
    reqValid = 1; reqWrite = wr; addr = a; wdata = wd;
    stalls = 0; reqc = 0; rdata = 0; maddr = 32'hFFFF_FFFF;
    we_seen = 0; bad_hs = 0; timeout = 1;
    for (int c = 0; c < 60; c++) begin
      @(negedge clk);
      if (!stall) begin
        rdata = readData;
        timeout = 0;
        break;
      end
      stalls++;
      if (memReq) begin
        reqc++;
        if (reqc == 1) begin
          maddr = memAddr;
          we_seen = memWe;
        end else if (memAddr !== maddr || memWe !== we_seen) begin
          bad_hs = 1;
        end
        if (wr && memWData !== wd) bad_hs = 1;
        if (reqc == lat + 1) begin
          memAck = 1;
          memRData = fill;
        end
      end
      step();
      memAck = 0; memRData = 0;
    end
    step();
    reqValid = 0; reqWrite = 0;
  endtask

  task automatic test_reset();
    reqValid = 0; reqWrite = 0; flush = 0; addr = 0; wdata = 0;
    memAck = 0; memRData = 0;
    rst_n = 0;
    #3;
    total++;
    if ({stall, memReq, memWe} !== 3'b000) $display("FAIL reset_ctl got %b exp 000", {stall, memReq, memWe});
    else passed++;
    total++;
    if ({memAddr, memWData} !== 64'h0) $display("FAIL reset_bus got %h exp 0", {memAddr, memWData});
    else passed++;
    total++;
    if ({hitCount, missCount, readData} !== 96'h0) $display("FAIL reset_cnt got %h exp 0", {hitCount, missCount, readData});
    else passed++;
    @(negedge clk);
    rst_n = 1;
    step();
  endtask

  task automatic test_load_miss();
    int st; logic [31:0] rd, ma; logic we, bad, to;
    cpu_access(0, 32'h100, 0, 32'hDEAD_BEEF, 3, st, rd, ma, we, bad, to);
    total++;
    if (to || st != 5) $display("FAIL miss_stall got %0d timeout %0d exp 5", st, to);
    else passed++;
    total++;
    if (ma !== 32'h100 || we !== 1'b0 || bad) $display("FAIL miss_req addr %h we %b bad %b exp 100/0/0", ma, we, bad);
    else passed++;
    total++;
    if (rd !== 32'hDEAD_BEEF) $display("FAIL miss_data got %h exp deadbeef", rd);
    else passed++;
    total++;
    if (missCount !== 32'd1 || hitCount !== 32'd1) $display("FAIL miss_cnt got m%0d h%0d exp m1 h1", missCount, hitCount);
    else passed++;
  endtask

  task automatic test_load_hit();
    int st; logic [31:0] rd, ma; logic we, bad, to;
    cpu_access(0, 32'h100, 0, 32'h0, 0, st, rd, ma, we, bad, to);
    total++;
    if (to || st != 0 || ma !== 32'hFFFF_FFFF) $display("FAIL hit_stall got %0d maddr %h exp 0 none", st, ma);
    else passed++;
    total++;
    if (rd !== 32'hDEAD_BEEF || hitCount !== 32'd2) $display("FAIL hit_data got %h h%0d exp deadbeef h2", rd, hitCount);
    else passed++;
    total++;
    if (memReq !== 1'b0) $display("FAIL hit_noreq got %b exp 0", memReq);
    else passed++;
  endtask

  task automatic test_store_hit();
    int st; logic [31:0] rd, ma; logic we, bad, to;
    cpu_access(1, 32'h100, 32'h1234_5678, 32'h0, 1, st, rd, ma, we, bad, to);
    total++;
    if (to || st != 3) $display("FAIL sthit_stall got %0d exp 3", st);
    else passed++;
    total++;
    if (ma !== 32'h100 || we !== 1'b1 || bad) $display("FAIL sthit_req addr %h we %b bad %b exp 100/1/0", ma, we, bad);
    else passed++;
    total++;
    if (memReq !== 1'b0 || memWe !== 1'b0) $display("FAIL sthit_drop got %b%b exp 00", memReq, memWe);
    else passed++;
    cpu_access(0, 32'h100, 0, 32'h0, 0, st, rd, ma, we, bad, to);
    total++;
    if (to || st != 0 || rd !== 32'h1234_5678) $display("FAIL sthit_read got %h stall %0d exp 12345678 0", rd, st);
    else passed++;
    total++;
    if (missCount !== 32'd1 || hitCount !== 32'd3) $display("FAIL sthit_cnt got m%0d h%0d exp m1 h3", missCount, hitCount);
    else passed++;
  endtask

  task automatic test_store_miss();
    int st; logic [31:0] rd, ma; logic we, bad, to;
    cpu_access(1, 32'h204, 32'hCAFE_F00D, 32'h0, 0, st, rd, ma, we, bad, to);
    total++;
    if (to || st != 2 || ma !== 32'h204 || we !== 1'b1 || bad) $display("FAIL stmiss_req stall %0d addr %h we %b exp 2/204/1", st, ma, we);
    else passed++;
    cpu_access(0, 32'h204, 0, 32'h0BAD_F00D, 2, st, rd, ma, we, bad, to);
    total++;
    if (to || st != 4 || ma !== 32'h204 || we !== 1'b0) $display("FAIL stmiss_noalloc stall %0d addr %h exp 4/204", st, ma);
    else passed++;
    total++;
    if (rd !== 32'h0BAD_F00D || missCount !== 32'd2 || hitCount !== 32'd4) $display("FAIL stmiss_fill got %h m%0d h%0d exp 0badf00d m2 h4", rd, missCount, hitCount);
    else passed++;
  endtask

  task automatic test_conflict();
    int st; logic [31:0] rd, ma; logic we, bad, to;
    do_reset();
    cpu_access(0, 32'h100, 0, 32'h1111_1111, 0, st, rd, ma, we, bad, to);
    total++;
    if (to || st != 2 || rd !== 32'h1111_1111) $display("FAIL conf_a got %h stall %0d exp 11111111 2", rd, st);
    else passed++;
    cpu_access(0, 32'h140, 0, 32'h2222_2222, 0, st, rd, ma, we, bad, to);
    total++;
    if (to || st != 2 || ma !== 32'h140 || rd !== 32'h2222_2222) $display("FAIL conf_b got %h addr %h stall %0d exp 22222222 140 2", rd, ma, st);
    else passed++;
    cpu_access(0, 32'h100, 0, 32'h3333_3333, 0, st, rd, ma, we, bad, to);
    total++;
    if (to || st != 2 || rd !== 32'h3333_3333) $display("FAIL conf_c got %h stall %0d exp 33333333 2", rd, st);
    else passed++;
    total++;
    if (missCount !== 32'd3 || hitCount !== 32'd3) $display("FAIL conf_cnt got m%0d h%0d exp m3 h3", missCount, hitCount);
    else passed++;
  endtask

  task automatic test_flush();
    int st; logic [31:0] rd, ma; logic we, bad, to;
    cpu_access(0, 32'h100, 0, 32'h0, 0, st, rd, ma, we, bad, to);
    total++;
    if (to || st != 0 || rd !== 32'h3333_3333) $display("FAIL fl_prehit got %h stall %0d exp 33333333 0", rd, st);
    else passed++;
    flush = 1;
    @(negedge clk);
    total++;
    if (stall !== 1'b1) $display("FAIL fl_stall got %b exp 1", stall);
    else passed++;
    step();
    flush = 0;
    cpu_access(0, 32'h100, 0, 32'h4444_4444, 0, st, rd, ma, we, bad, to);
    total++;
    if (to || st != 2 || rd !== 32'h4444_4444 || missCount !== 32'd4) $display("FAIL fl_miss got %h stall %0d m%0d exp 44444444 2 m4", rd, st, missCount);
    else passed++;
    reqValid = 1; reqWrite = 0; addr = 32'h100; flush = 1;
    @(negedge clk);
    total++;
    if (stall !== 1'b1 || readData !== 32'h0) $display("FAIL fl_prio got stall %b data %h exp 1 0", stall, readData);
    else passed++;
    step();
    flush = 0; reqValid = 0;
    total++;
    if (memReq !== 1'b0 || missCount !== 32'd4) $display("FAIL fl_prio_req got %b m%0d exp 0 m4", memReq, missCount);
    else passed++;
    cpu_access(0, 32'h100, 0, 32'h5555_5555, 0, st, rd, ma, we, bad, to);
    total++;
    if (to || st != 2 || rd !== 32'h5555_5555) $display("FAIL fl_prio_miss got %h stall %0d exp 55555555 2", rd, st);
    else passed++;
    total++;
    if (missCount !== 32'd5 || hitCount !== 32'd6) $display("FAIL fl_cnt got m%0d h%0d exp m5 h6", missCount, hitCount);
    else passed++;
  endtask

  task automatic test_reset_mid_fill();
    int st; logic [31:0] rd, ma; logic we, bad, to;
    reqValid = 1; reqWrite = 0; addr = 32'h300;
    step();
    @(negedge clk);
    total++;
    if (memReq !== 1'b1 || memAddr !== 32'h300) $display("FAIL rf_req got %b %h exp 1 300", memReq, memAddr);
    else passed++;
    #1 rst_n = 0;
    #1;
    total++;
    if (memReq !== 1'b0 || missCount !== 32'd0) $display("FAIL rf_async got %b m%0d exp 0 m0", memReq, missCount);
    else passed++;
    reqValid = 0;
    @(negedge clk);
    rst_n = 1;
    step();
    cpu_access(0, 32'h100, 0, 32'h6666_6666, 1, st, rd, ma, we, bad, to);
    total++;
    if (to || st != 3 || ma !== 32'h100 || rd !== 32'h6666_6666) $display("FAIL rf_after got %h addr %h stall %0d exp 66666666 100 3", rd, ma, st);
    else passed++;
    cpu_access(0, 32'h300, 0, 32'h7777_7777, 0, st, rd, ma, we, bad, to);
    total++;
    if (to || st != 2 || rd !== 32'h7777_7777 || missCount !== 32'd2) $display("FAIL rf_inval got %h stall %0d m%0d exp 77777777 2 m2", rd, st, missCount);
    else passed++;
  endtask

  initial begin
    test_reset();
    test_load_miss();
    test_load_hit();
    test_store_hit();
    test_store_miss();
    test_conflict();
    test_flush();
    test_reset_mid_fill();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
